// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the shared memory
// port served by mem_arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester side, into arbiter
//   gnt0/gnt1, ack0/ack1, rdata, busy               : requester side, from arbiter
//   mem_addr, mem_wdata, mem_we                     : memory side, from arbiter
//   mem_rdata                                       : memory side, into arbiter
// slave  : the arbiter's view.
// master : the view of the surrounding system (requesters + memory).
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, round-robin arbiter for a single memory port.
// Port 0 is the CPU fetch/operand path, port 1 the loader/debug port.
// A granted access holds address/data/direction for ACCESS_CYCLES cycles
// (legal range 1..15), then returns read data with a one-cycle ack.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requests, grants, acks, memory port)
module mem_arbiter #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_sel;
    logic          r_last;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;

    logic          w_any_req;
    logic          w_win;
    logic          w_final;
    logic          w_gnt0_nxt;
    logic          w_gnt1_nxt;
    logic          w_ack0_nxt;
    logic          w_ack1_nxt;
    logic          w_busy_nxt;
    logic          w_mem_we;

    assign w_any_req = bus.req0 | bus.req1;
    // On a tie the port that did not win last time gets the grant.
    assign w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_final   = (r_state == ST_BUSY) && (r_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_final)   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered handshake outputs, plus
    // the write strobe, which is decoded from registered state only.
    always_comb begin
        w_gnt0_nxt = r_gnt0;
        w_gnt1_nxt = r_gnt1;
        w_busy_nxt = r_busy;
        w_ack0_nxt = 1'b0;
        w_ack1_nxt = 1'b0;
        w_mem_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_gnt0_nxt = ~w_win;
                    w_gnt1_nxt = w_win;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_final) begin
                    w_mem_we   = r_we;
                    w_ack0_nxt = ~r_sel;
                    w_ack1_nxt = r_sel;
                end
            end
            ST_RESP: begin
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_gnt0 <= w_gnt0_nxt;
            r_gnt1 <= w_gnt1_nxt;
            r_ack0 <= w_ack0_nxt;
            r_ack1 <= w_ack1_nxt;
            r_busy <= w_busy_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_win;
                        r_last  <= w_win;
                        r_we    <= w_win ? bus.we1    : bus.we0;
                        r_addr  <= w_win ? bus.addr1  : bus.addr0;
                        r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Captured before the write lands, so a write
                        // returns the previous contents.
                        r_rdata <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.busy      = r_busy;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = w_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Two instances run side by
// side: d1 with ACCESS_CYCLES=1 and d3 with ACCESS_CYCLES=3, each with its own
// memory model. Stimulus pushes expected transactions; a negedge monitor
// checks grants, acks, read data, ack timing and write strobes against them.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.AW(8), .DW(8)) b1 ();
    mem_arbiter_if #(.AW(8), .DW(8)) b3 ();

    mem_arbiter #(.AW(8), .DW(8), .ACCESS_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    mem_arbiter #(.AW(8), .DW(8), .ACCESS_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    // Memory models: preloaded on the first edge, then written on mem_we.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            mem1[8'h10] <= 8'h5A;
            mem1[8'h20] <= 8'h99;
            mem1[8'h40] <= 8'h11;
            mem1[8'h41] <= 8'h22;
            mem3[8'h30] <= 8'hA5;
            mem3[8'h31] <= 8'h5B;
            mem3[8'h50] <= 8'h77;
            mem_ready   <= 1'b1;
        end else begin
            if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
            if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
        end
    end

    assign b1.mem_rdata = mem1[b1.mem_addr];
    assign b3.mem_rdata = mem3[b3.mem_addr];

    typedef struct {
        int         port;
        logic [7:0] addr;
        logic [7:0] rdata;
        int         ack_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
    } wexp_t;

    exp_t  q1 [$];
    exp_t  q3 [$];
    wexp_t wq1 [$];
    wexp_t wq3 [$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (b1.gnt0 | b1.gnt1) begin
                chk("d1_gnt_excl", 32'(b1.gnt0 & b1.gnt1), 0);
                chk("d1_busy", 32'(b1.busy), 1);
                chk("d1_gnt_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    chk("d1_gnt_port", 32'(b1.gnt1), q1[0].port);
                    chk("d1_mem_addr", 32'(b1.mem_addr), 32'(q1[0].addr));
                end
            end else begin
                chk("d1_busy_idle", 32'(b1.busy), 0);
            end
            if (b1.ack0 | b1.ack1) begin
                chk("d1_ack_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    chk("d1_ack_port", 32'(b1.ack1), q1[0].port);
                    chk("d1_rdata", 32'(b1.rdata), 32'(q1[0].rdata));
                    chk("d1_ack_cycle", cyc, q1[0].ack_cyc);
                    void'(q1.pop_front());
                end
            end
            if (b1.mem_we) begin
                chk("d1_we_expected", 32'(wq1.size() != 0), 1);
                if (wq1.size() != 0) begin
                    chk("d1_we_addr", 32'(b1.mem_addr), 32'(wq1[0].addr));
                    chk("d1_we_wdata", 32'(b1.mem_wdata), 32'(wq1[0].wdata));
                    void'(wq1.pop_front());
                end
            end

            if (b3.gnt0 | b3.gnt1) begin
                chk("d3_gnt_excl", 32'(b3.gnt0 & b3.gnt1), 0);
                chk("d3_busy", 32'(b3.busy), 1);
                chk("d3_gnt_expected", 32'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    chk("d3_gnt_port", 32'(b3.gnt1), q3[0].port);
                    chk("d3_mem_addr", 32'(b3.mem_addr), 32'(q3[0].addr));
                end
            end else begin
                chk("d3_busy_idle", 32'(b3.busy), 0);
            end
            if (b3.ack0 | b3.ack1) begin
                chk("d3_ack_expected", 32'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    chk("d3_ack_port", 32'(b3.ack1), q3[0].port);
                    chk("d3_rdata", 32'(b3.rdata), 32'(q3[0].rdata));
                    chk("d3_ack_cycle", cyc, q3[0].ack_cyc);
                    void'(q3.pop_front());
                end
            end
            if (b3.mem_we) begin
                chk("d3_we_expected", 32'(wq3.size() != 0), 1);
                if (wq3.size() != 0) begin
                    chk("d3_we_addr", 32'(b3.mem_addr), 32'(wq3[0].addr));
                    chk("d3_we_wdata", 32'(b3.mem_wdata), 32'(wq3[0].wdata));
                    void'(wq3.pop_front());
                end
            end
        end
    end

    task automatic drive(input int inst, input int port, input logic req,
                         input logic we, input logic [7:0] a, input logic [7:0] d);
        if (inst == 1) begin
            if (port == 0) begin
                b1.req0 = req; b1.we0 = we; b1.addr0 = a; b1.wdata0 = d;
            end else begin
                b1.req1 = req; b1.we1 = we; b1.addr1 = a; b1.wdata1 = d;
            end
        end else begin
            if (port == 0) begin
                b3.req0 = req; b3.we0 = we; b3.addr0 = a; b3.wdata0 = d;
            end else begin
                b3.req1 = req; b3.we1 = we; b3.addr1 = a; b3.wdata1 = d;
            end
        end
    endtask

    function automatic logic ack_of(input int inst, input int port);
        if (inst == 1) return (port == 0) ? b1.ack0 : b1.ack1;
        return (port == 0) ? b3.ack0 : b3.ack1;
    endfunction

    task automatic push_exp(input int inst, input int port, input logic [7:0] a,
                            input logic [7:0] rd, input int ack_cyc);
        exp_t e;
        e.port = port; e.addr = a; e.rdata = rd; e.ack_cyc = ack_cyc;
        if (inst == 1) q1.push_back(e);
        else           q3.push_back(e);
    endtask

    task automatic push_wr(input int inst, input logic [7:0] a, input logic [7:0] d);
        wexp_t w;
        w.addr = a; w.wdata = d;
        if (inst == 1) wq1.push_back(w);
        else           wq3.push_back(w);
    endtask

    // Wait for the ack of a request already driven, bounded; drops req on
    // the ack cycle so no extra access follows.
    task automatic wait_ack(input int inst, input int port);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ack_of(inst, port)) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_timeout", 32'(got), 1);
        drive(inst, port, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // One transaction starting from an idle arbiter.
    task automatic do_txn(input int inst, input int port, input logic we,
                          input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int lat;
        lat = (inst == 1) ? 1 : 3;
        @(negedge clk);
        push_exp(inst, port, a, exp_rd, cyc + 1 + lat);
        if (we) push_wr(inst, a, d);
        drive(inst, port, 1'b1, we, a, d);
        wait_ack(inst, port);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_d1_gnt0",  32'(b1.gnt0), 0);
        chk("rst_d1_gnt1",  32'(b1.gnt1), 0);
        chk("rst_d1_ack0",  32'(b1.ack0), 0);
        chk("rst_d1_ack1",  32'(b1.ack1), 0);
        chk("rst_d1_busy",  32'(b1.busy), 0);
        chk("rst_d1_we",    32'(b1.mem_we), 0);
        chk("rst_d1_rdata", 32'(b1.rdata), 0);
        chk("rst_d1_addr",  32'(b1.mem_addr), 0);
        chk("rst_d1_wdata", 32'(b1.mem_wdata), 0);
        chk("rst_d3_gnt0",  32'(b3.gnt0), 0);
        chk("rst_d3_gnt1",  32'(b3.gnt1), 0);
        chk("rst_d3_ack0",  32'(b3.ack0), 0);
        chk("rst_d3_ack1",  32'(b3.ack1), 0);
        chk("rst_d3_busy",  32'(b3.busy), 0);
        chk("rst_d3_we",    32'(b3.mem_we), 0);
        chk("rst_d3_rdata", 32'(b3.rdata), 0);
        chk("rst_d3_addr",  32'(b3.mem_addr), 0);
        chk("rst_d3_wdata", 32'(b3.mem_wdata), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        for (int i = 1; i <= 3; i += 2)
            for (int p = 0; p < 2; p++)
                drive(i, p, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single read, one-cycle access
        do_txn(1, 0, 1'b0, 8'h10, 8'h00, 8'h5A);

        // Write on port 1 returns old contents, then read back
        do_txn(1, 1, 1'b1, 8'h20, 8'hC3, 8'h99);
        do_txn(1, 1, 1'b0, 8'h20, 8'h00, 8'hC3);

        // Asynchronous reset mid-simulation, checked before the next edge
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();

        // Contention: both held from reset release, grants alternate 0,1,0,1
        drive(1, 0, 1'b1, 1'b0, 8'h40, 8'h00);
        drive(1, 1, 1'b1, 1'b0, 8'h41, 8'h00);
        @(negedge clk);
        c = cyc;
        push_exp(1, 0, 8'h40, 8'h11, c + 2);
        push_exp(1, 1, 8'h41, 8'h22, c + 5);
        push_exp(1, 0, 8'h40, 8'h11, c + 8);
        push_exp(1, 1, 8'h41, 8'h22, c + 11);
        rst_n = 1'b1;
        while (cyc < c + 11) @(negedge clk);
        drive(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        chk("contention_acks_left", q1.size(), 0);

        // Three-cycle read; address input changes during BUSY
        @(negedge clk);
        push_exp(3, 0, 8'h30, 8'hA5, cyc + 4);
        drive(3, 0, 1'b1, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        b3.addr0 = 8'h31;
        wait_ack(3, 0);

        // Reset during the second BUSY cycle of a write aborts it
        @(negedge clk);
        push_exp(3, 0, 8'h50, 8'h00, 0);
        drive(3, 0, 1'b1, 1'b1, 8'h50, 8'hEE);
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(b3.busy), 1);
        #1 rst_n = 1'b0;
        q3.delete();
        drive(3, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("abort_busy", 32'(b3.busy), 0);
        chk("abort_gnt0", 32'(b3.gnt0), 0);
        chk("abort_we", 32'(b3.mem_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_mem_unchanged", 32'(mem3[8'h50]), 32'h77);
        chk("abort_idle", 32'(b3.busy), 0);

        chk("final_q1_empty", q1.size(), 0);
        chk("final_q3_empty", q3.size(), 0);
        chk("final_wq1_empty", wq1.size(), 0);
        chk("final_wq3_empty", wq3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 8-bit memory port between the CPU's fetch/operand path (port 0) and the program loader/debug port (port 1). It serialises accesses with a req/ack handshake and round-robin fairness. It holds the winner's address, data and direction stable for a programmable access time, then returns read data with a one-cycle acknowledge. The CPU's `addr` register no longer drives memory directly; it drives `addr0`.

## Interface
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `ACCESS_CYCLES`, default 1: memory access time in cycles. Legal values are 1–15; other values are illegal.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req0` / `req1`, in, 1: access request; held until the matching ack.
- `we0` / `we1`, in, 1: 1 = write, 0 = read; sampled at grant.
- `addr0` / `addr1`, in, AW: access address; sampled at grant.
- `wdata0` / `wdata1`, in, DW: write data; sampled at grant.
- `gnt0` / `gnt1`, out, 1: port owns the memory (BUSY and RESP).
- `ack0` / `ack1`, out, 1: one-cycle completion pulse.
- `rdata`, out, DW: shared read data; valid only while an ack is high.
- `busy`, out, 1: state is not IDLE.
- `mem_addr`, out, AW: memory address.
- `mem_wdata`, out, DW: memory write data.
- `mem_we`, out, 1: memory write strobe; memory writes on the rising edge.
- `mem_rdata`, in, DW: memory read data, combinational from `mem_addr`.

## Operation
**States:** IDLE, BUSY, RESP. Internal registers are `sel` (winner), `last` (last winner), a down-counter `cnt`, and the latched `we`/`addr`/`wdata`.

**IDLE**
- If no request is present, stay in IDLE.
- If exactly one `req` is high, grant that port.
- If both are high, grant the port not equal to `last`. `last` resets to 1, so port 0 wins the first tie.
- On grant:
  - `sel` and `last` are set to the winner.
  - The winner's we/addr/wdata are latched into the internal registers.
  - `cnt` is loaded with ACCESS_CYCLES-1.
  - Next state is BUSY.

**BUSY**
- `mem_addr` and `mem_wdata` come from the latched values; they are unaffected by input changes.
- If `cnt` != 0, decrement `cnt` and stay in BUSY.
- If `cnt` == 0 (final BUSY cycle):
  - `mem_we` equals the latched `we`.
  - `rdata` is loaded with `mem_rdata`. For a write this is the pre-write contents.
  - Next state is RESP.

**RESP**
- `ack[sel]` is high for exactly one cycle.
- Always returns to IDLE; `req` is not sampled in RESP.

**Outputs**
- `gnt[sel]` is high throughout BUSY and RESP; the other gnt stays low.
- `mem_we` is high for exactly one cycle per write and never for a read.
- In IDLE, `mem_addr`/`mem_wdata` hold their last latched values and `mem_we` is 0.
- Dropping `req` mid-transaction is ignored: the access completes and the ack still pulses.

**Back-to-back and fairness**
- A requester that keeps `req` high after its ack gets a new transaction in the following IDLE cycle, subject to arbitration.
- A requester that drops `req` on the edge after seeing ack gets no extra access.
- With both requests held continuously, grants strictly alternate.

**Reset** (asynchronous, any state)
- State goes to IDLE.
- `gnt0`, `gnt1`, `ack0`, `ack1`, `busy`, `mem_we` = 0.
- `rdata`, `mem_addr`, `mem_wdata`, `cnt` = 0.
- `sel` = 0, `last` = 1.
- An in-flight access is aborted: no write strobe and no ack.

## Timing
- Request sampled at edge E0 (IDLE to BUSY); gnt is high from E0.
- `mem_we`, if a write, is high in the cycle before edge E0+ACCESS_CYCLES; the write occurs at that edge.
- Ack is high in the cycle after E0+ACCESS_CYCLES: ACCESS_CYCLES+1 cycles after the request is sampled.
- The transaction period is ACCESS_CYCLES+2 cycles (IDLE + BUSY×N + RESP).
- gnt, ack, busy and rdata are registered. `mem_we`, `mem_addr` and `mem_wdata` are decoded only from registered state, with no input-to-output combinational paths.

## Test plan
1. Reset: assert `rst_n`=0 mid-simulation → every output is 0 asynchronously, before the next clock edge.
2. Single read, ACCESS_CYCLES=1: mem[0x10]=0x5A; req0 with addr0=0x10 sampled at E0 → gnt0 from E0, ack0 pulses in the cycle after E0+1 with rdata=0x5A, `mem_we` never asserts.
3. Write then read on port 1: req1, we1=1, addr1=0x20, wdata1=0xC3 → exactly one `mem_we` pulse with mem_addr=0x20 and mem_wdata=0xC3; a following read of 0x20 acks with rdata=0xC3.
4. Contention: req0 and req1 held high from reset release → grant order 0,1,0,1 with acks every 3 cycles; 4 acks within 12 cycles.
5. ACCESS_CYCLES=3: read of 0x30; change addr0 to 0x31 during BUSY → mem_addr stays 0x30 throughout; ack arrives 4 cycles after sampling.
6. Reset mid-write: ACCESS_CYCLES=3; pulse `rst_n` low during the second BUSY cycle → no `mem_we` pulse, no ack, state IDLE; target memory location unchanged.
